// File: rtl/serial_subtractor_pkg.sv
// Shared arithmetic definitions: the sequencing states for the serial
// arithmetic blocks and the counter-width helper.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bits needed to count 0..w-1; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bus for serial_subtractor.
// SERIAL_SUBTRACTOR_OVF_EN adds the signed-overflow flag ovf.
interface serial_subtractor_if #(parameter int WIDTH = 4);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic             ovf;

  modport master (output start, a, b, input busy, done, diff, bout, ovf);
  modport slave  (input start, a, b, output busy, done, diff, bout, ovf);
`else
  modport master (output start, a, b, input busy, done, diff, bout);
  modport slave  (input start, a, b, output busy, done, diff, bout);
`endif

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// Combinational 1-bit full-subtractor cell: x - y - bin.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bin;
  assign bo = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor, diff = a - b over WIDTH cycles.
// SERIAL_SUBTRACTOR_OVF_EN adds a signed two's-complement overflow flag.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_sh_reg, b_sh_reg, res_reg, diff_reg;
  logic             br_reg, bout_reg;
  logic [CW-1:0]    cnt_reg;
  logic             d_bit, bo_bit, last_bit;
  logic [WIDTH-1:0] res_next;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic a_msb_reg, b_msb_reg, ovf_reg;
`endif

  full_subtractor u_fs (
    .x   (a_sh_reg[0]),
    .y   (b_sh_reg[0]),
    .bin (br_reg),
    .d   (d_bit),
    .bo  (bo_bit)
  );

  assign last_bit = (cnt_reg == CW'(WIDTH - 1));
  assign res_next = {d_bit, res_reg[WIDTH-1:1]};

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = SHIFT;
      SHIFT:   if (last_bit)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_reg  <= '0;
      b_sh_reg  <= '0;
      res_reg   <= '0;
      diff_reg  <= '0;
      br_reg    <= 1'b0;
      bout_reg  <= 1'b0;
      cnt_reg   <= '0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      a_msb_reg <= 1'b0;
      b_msb_reg <= 1'b0;
      ovf_reg   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            a_sh_reg  <= bus.a;
            b_sh_reg  <= bus.b;
            res_reg   <= '0;
            br_reg    <= 1'b0;
            cnt_reg   <= '0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            a_msb_reg <= bus.a[WIDTH-1];
            b_msb_reg <= bus.b[WIDTH-1];
`endif
          end
        end
        SHIFT: begin
          a_sh_reg <= a_sh_reg >> 1;
          b_sh_reg <= b_sh_reg >> 1;
          res_reg  <= res_next;
          br_reg   <= bo_bit;
          cnt_reg  <= cnt_reg + 1'b1;
          // The final bit is folded in directly so diff is ready as DONE starts.
          if (last_bit) begin
            diff_reg <= res_next;
            bout_reg <= bo_bit;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            ovf_reg  <= (a_msb_reg != b_msb_reg) && (d_bit != a_msb_reg);
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state_reg == SHIFT);
  assign bus.done = (state_reg == DONE);
  assign bus.diff = diff_reg;
  assign bus.bout = bout_reg;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  assign bus.ovf  = ovf_reg;
`endif

endmodule
